// File: rtl/parallel_send_if.sv
// ============================================================================
// Module      : parallel_send_if
// Description : Control/data bundle between a BER pattern transmitter and
//               its host/checker. The transmitter sits on the master side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface parallel_send_if;
  logic        START;
  logic        EN;
  logic        ERR_EN;
  logic [63:0] ERR_MASK;
  logic        INIT;
  logic        DOPUSH;
  logic [63:0] DOUT;
  logic        BUSY;
  logic        DONE;
  logic [57:0] SENT_CNT;
  logic [63:0] INJ_CNT;

  modport master (
    input  START, EN, ERR_EN, ERR_MASK,
    output INIT, DOPUSH, DOUT, BUSY, DONE, SENT_CNT, INJ_CNT
  );

  modport slave (
    output START, EN, ERR_EN, ERR_MASK,
    input  INIT, DOPUSH, DOUT, BUSY, DONE, SENT_CNT, INJ_CNT
  );
endinterface

`default_nettype wire

// File: rtl/parallel_send.sv
// ============================================================================
// Module      : parallel_send
// Description : BER pattern transmitter. START emits a one-cycle INIT marker,
//               waits INIT_GAP quiet cycles, then pushes BURST_LEN 64-bit
//               lfsr32x2 words (sequence from seed 0, continuing across
//               bursts until CLR/reset). Optional bit-error injection with
//               sent-word and injected-bit counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parallel_send #(
  parameter int BURST_LEN = 1024,  // 1..2048
  parameter int INIT_GAP  = 2      // 1..15
) (
  input  wire                  CLK,
  input  wire                  RSTX,
  input  wire                  CLR,
  parallel_send_if.master      bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_GAP  = 2'd2,
    S_SEND = 2'd3
  } state_t;

  localparam logic [3:0]  C_GAP_LOAD  = 4'(INIT_GAP - 1);
  localparam logic [10:0] C_WORD_LOAD = 11'(BURST_LEN - 1);

  // One 32-bit XNOR LFSR step (taps 32,22,2,1); all-zero is a legal state,
  // which is what lets the sequence start from seed 0.
  function automatic logic [31:0] step32(input logic [31:0] x);
    return {x[30:0], ~(x[31] ^ x[21] ^ x[1] ^ x[0])};
  endfunction

  // Shared PRBS step: two LFSR steps from the newest half, newest in the top.
  function automatic logic [63:0] lfsr32x2(input logic [63:0] s);
    logic [31:0] a;
    logic [31:0] b;
    a = step32(s[63:32]);
    b = step32(a);
    return {b, a};
  endfunction

  function automatic logic [6:0] popcnt64(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + {6'd0, v[i]};
    return c;
  endfunction

  state_t      state_q,  state_d;
  logic [3:0]  gap_q,    gap_d;
  logic [10:0] word_q,   word_d;
  logic [63:0] prbs_q,   prbs_d;
  logic        init_q,   init_d;
  logic        dopush_q, dopush_d;
  logic [63:0] dout_q,   dout_d;
  logic        done_q,   done_d;
  logic [57:0] sent_q,   sent_d;
  logic [63:0] inj_q,    inj_d;

  logic        push;
  logic [64:0] inj_sum;

  // Next-state, datapath and counter update; CLR overrides everything last.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    word_d   = word_q;
    prbs_d   = prbs_q;
    init_d   = 1'b0;
    dopush_d = 1'b0;
    dout_d   = dout_q;
    done_d   = 1'b0;
    sent_d   = sent_q;
    inj_d    = inj_q;
    push     = (state_q == S_SEND) && bus.EN;
    inj_sum  = {1'b0, inj_q} + {58'd0, popcnt64(bus.ERR_MASK)};

    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          state_d = S_INIT;
          init_d  = 1'b1;
        end
      end
      // The INIT cycle itself counts as the first gap cycle, so that the
      // first DOPUSH lands INIT_GAP+1 cycles after the INIT marker.
      S_INIT: begin
        gap_d = C_GAP_LOAD;
        if (INIT_GAP == 1) begin
          state_d = S_SEND;
          word_d  = C_WORD_LOAD;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        gap_d = gap_q - 4'd1;
        if (gap_q == 4'd1) begin
          state_d = S_SEND;
          word_d  = C_WORD_LOAD;
        end
      end
      S_SEND: begin
        if (push) begin
          if (word_q == 11'd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            word_d = word_q - 11'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      dopush_d = 1'b1;
      dout_d   = prbs_q ^ (bus.ERR_EN ? bus.ERR_MASK : 64'd0);
      prbs_d   = lfsr32x2(prbs_q);
      sent_d   = sent_q + 58'd1;
      if (bus.ERR_EN) begin
        // Carry out of the 65-bit sum pins the counter at all-ones.
        inj_d = inj_sum[64] ? {64{1'b1}} : inj_sum[63:0];
      end
    end

    if (CLR) begin
      state_d  = S_IDLE;
      gap_d    = '0;
      word_d   = '0;
      prbs_d   = '0;
      init_d   = 1'b0;
      dopush_d = 1'b0;
      dout_d   = '0;
      done_d   = 1'b0;
      sent_d   = '0;
      inj_d    = '0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q  <= S_IDLE;
      gap_q    <= '0;
      word_q   <= '0;
      prbs_q   <= '0;
      init_q   <= 1'b0;
      dopush_q <= 1'b0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      sent_q   <= '0;
      inj_q    <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      word_q   <= word_d;
      prbs_q   <= prbs_d;
      init_q   <= init_d;
      dopush_q <= dopush_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      sent_q   <= sent_d;
      inj_q    <= inj_d;
    end
  end

  assign bus.INIT     = init_q;
  assign bus.DOPUSH   = dopush_q;
  assign bus.DOUT     = dout_q;
  assign bus.DONE     = done_q;
  assign bus.BUSY     = (state_q != S_IDLE);
  assign bus.SENT_CNT = sent_q;
  assign bus.INJ_CNT  = inj_q;

endmodule

`default_nettype wire
